// File: rtl/max6675_read_scheduler_if.sv
// Signal bundle between the MAX6675 read scheduler, the board SPI pins and the temperature consumer.
// The master modport is the scheduler side; the slave modport is everything around it.
interface max6675_read_scheduler_if;
   logic        enable;
   logic        trig;
   logic        spi_so;
   logic        spi_cs_n;
   logic        spi_sclk;
   logic [11:0] temp_raw;
   logic [9:0]  temp_int;
   logic        tc_open;
   logic        frame_err;
   logic        data_valid;
   logic        busy;

   modport master (
      input  enable, trig, spi_so,
      output spi_cs_n, spi_sclk, temp_raw, temp_int, tc_open, frame_err, data_valid, busy
   );

   modport slave (
      output enable, trig, spi_so,
      input  spi_cs_n, spi_sclk, temp_raw, temp_int, tc_open, frame_err, data_valid, busy
   );
endinterface

// File: rtl/max6675_read_scheduler.sv
// SPI master and read scheduler for the MAX6675: waits out the conversion time, clocks in the
// 16-bit frame MSB-first and publishes temperature, open-thermocouple and frame-error results.
module max6675_read_scheduler #(
   parameter int SCLK_HALF   = 8,
   parameter int CS_SETUP    = 8,
   parameter int CONV_CYCLES = 11_500_000
) (
   input  logic                      clk,
   input  logic                      rst,
   max6675_read_scheduler_if.master  bus
);

   localparam int MAX_AB  = (CONV_CYCLES > CS_SETUP) ? CONV_CYCLES : CS_SETUP;
   localparam int MAX_ALL = (MAX_AB > SCLK_HALF) ? MAX_AB : SCLK_HALF;
   localparam int CW      = $clog2(MAX_ALL + 1);

   localparam logic [CW-1:0] CONV_LAST  = CW'(CONV_CYCLES - 1);
   localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
   localparam logic [CW-1:0] HALF_LAST  = CW'(SCLK_HALF - 1);
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);

   localparam logic [2:0] S_CONV_WAIT = 3'd0;
   localparam logic [2:0] S_IDLE      = 3'd1;
   localparam logic [2:0] S_SETUP     = 3'd2;
   localparam logic [2:0] S_SHIFT     = 3'd3;
   localparam logic [2:0] S_DONE      = 3'd4;

   // Dummy bit (15) and device ID bit (1) must both read back as zero.
   function automatic logic frame_check(input logic [15:0] frame);
      return frame[15] | frame[1];
   endfunction

   logic [2:0]    state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [4:0]    bit_r, bit_s;
   logic          sclk_r, sclk_s;
   logic [15:0]   frame_r, frame_s;
   logic          pending_r, pending_s;
   logic          cs_n_r;
   logic          busy_r;
   logic          data_valid_r;
   logic [11:0]   temp_raw_r;
   logic          tc_open_r;
   logic          frame_err_r;

   // Next-state, counters, sclk phase and frame shifting.
   always_comb begin
      state_s   = state_r;
      cnt_s     = cnt_r;
      bit_s     = bit_r;
      sclk_s    = sclk_r;
      frame_s   = frame_r;
      if (bus.trig && (state_r != S_IDLE)) begin
         pending_s = 1'b1;
      end else begin
         pending_s = pending_r;
      end

      case (state_r)
         S_CONV_WAIT: begin
            if (cnt_r == CONV_LAST) begin
               state_s = S_IDLE;
               cnt_s   = CNT_ZERO;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         S_IDLE: begin
            if (bus.enable || bus.trig || pending_r) begin
               state_s   = S_SETUP;
               cnt_s     = CNT_ZERO;
               pending_s = 1'b0;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_SETUP: begin
            if (cnt_r == SETUP_LAST) begin
               state_s = S_SHIFT;
               cnt_s   = CNT_ZERO;
               bit_s   = 5'd0;
               sclk_s  = 1'b0;
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         S_SHIFT: begin
            if (cnt_r == HALF_LAST) begin
               cnt_s = CNT_ZERO;
               if (!sclk_r) begin
                  // Sample SO on the clk edge that raises sclk.
                  sclk_s  = 1'b1;
                  frame_s = {frame_r[14:0], bus.spi_so};
               end else if (bit_r == 5'd15) begin
                  sclk_s  = 1'b0;
                  state_s = S_DONE;
               end else begin
                  sclk_s = 1'b0;
                  bit_s  = bit_r + 5'd1;
               end
            end else begin
               cnt_s = cnt_r + CNT_ONE;
            end
         end
         S_DONE: begin
            state_s = S_CONV_WAIT;
            cnt_s   = CNT_ZERO;
         end
         default: begin
            state_s = S_CONV_WAIT;
            cnt_s   = CNT_ZERO;
            sclk_s  = 1'b0;
         end
      endcase
   end

   // State registers and registered outputs; pin outputs follow the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= S_CONV_WAIT;
         cnt_r        <= CNT_ZERO;
         bit_r        <= 5'd0;
         sclk_r       <= 1'b0;
         frame_r      <= 16'h0000;
         pending_r    <= 1'b0;
         cs_n_r       <= 1'b1;
         busy_r       <= 1'b1;
         data_valid_r <= 1'b0;
         temp_raw_r   <= 12'h000;
         tc_open_r    <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         bit_r        <= bit_s;
         sclk_r       <= sclk_s;
         frame_r      <= frame_s;
         pending_r    <= pending_s;
         cs_n_r       <= !((state_s == S_SETUP) || (state_s == S_SHIFT));
         busy_r       <= (state_s != S_IDLE);
         data_valid_r <= (state_s == S_DONE);
         if (state_s == S_DONE) begin
            temp_raw_r  <= frame_s[14:3];
            tc_open_r   <= frame_s[2];
            frame_err_r <= frame_check(frame_s);
         end
      end
   end

   assign bus.spi_cs_n   = cs_n_r;
   assign bus.spi_sclk   = sclk_r;
   assign bus.temp_raw   = temp_raw_r;
   assign bus.temp_int   = temp_raw_r[11:2];
   assign bus.tc_open    = tc_open_r;
   assign bus.frame_err  = frame_err_r;
   assign bus.data_valid = data_valid_r;
   assign bus.busy       = busy_r;

endmodule

// File: tb/tb_max6675_read_scheduler.sv
// Self-checking bench for max6675_read_scheduler: a MAX6675 SO model plus an arithmetic reference
// for the result fields and the cycle-level schedule (conversion wait, latency, frame period).
module tb_max6675_read_scheduler;
   localparam int CONV   = 100;
   localparam int HALF   = 2;
   localparam int SETUP  = 3;
   localparam int LAT    = 1 + SETUP + 32 * HALF + 1;
   localparam int PERIOD = CONV + LAT;

   logic clk = 1'b0;
   logic rst = 1'b0;

   max6675_read_scheduler_if bus ();

   max6675_read_scheduler #(
      .SCLK_HALF  (HALF),
      .CS_SETUP   (SETUP),
      .CONV_CYCLES(CONV)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial forever #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int rises[$];
   int gaps[$];
   int dv_cnt = 0;
   int dv_cyc = -1;
   int csfall_cyc = -1;
   int csrise_cyc = -1;
   int busylow_cyc = -1;
   logic [15:0] dev_frame = 16'h0000;
   logic [15:0] last_frame = 16'h0000;
   int so_idx = 0;

   // Reference: result fields from the frame with plain arithmetic.
   function automatic logic [11:0] m_raw(input logic [15:0] f);
      return 12'(f / 16'd8);
   endfunction
   function automatic logic [9:0] m_int(input logic [15:0] f);
      return 10'(m_raw(f) / 12'd4);
   endfunction
   function automatic logic m_open(input logic [15:0] f);
      return ((f / 16'd4) % 16'd2) == 16'd1;
   endfunction
   function automatic logic m_err(input logic [15:0] f);
      return (f >= 16'h8000) || (((f / 16'd2) % 16'd2) == 16'd1);
   endfunction

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Device model: first bit on cs_n fall, next bit on every sclk fall.
   initial begin
      bus.spi_so = 1'b0;
      forever begin
         @(negedge bus.spi_cs_n);
         so_idx = 15;
         bus.spi_so = dev_frame[15];
      end
   end
   initial forever begin
      @(negedge bus.spi_sclk);
      if (!bus.spi_cs_n && so_idx > 0) begin
         so_idx--;
         bus.spi_so = dev_frame[so_idx];
      end
   end

   // Event monitor sampling on the falling clk edge.
   initial begin
      logic sq, cq, bq;
      sq = 1'b0; cq = 1'b1; bq = 1'b1;
      forever begin
         @(negedge clk);
         if (bus.spi_sclk === 1'b1 && sq === 1'b0) rises.push_back(cyc);
         if (bus.spi_cs_n === 1'b0 && cq === 1'b1) begin
            csfall_cyc = cyc;
            if (csrise_cyc >= 0) gaps.push_back(cyc - csrise_cyc);
         end
         if (bus.spi_cs_n === 1'b1 && cq === 1'b0) csrise_cyc = cyc;
         if (bus.data_valid === 1'b1) begin
            dv_cnt++;
            dv_cyc = cyc;
         end
         if (bus.busy === 1'b0 && bq === 1'b1) busylow_cyc = cyc;
         sq = bus.spi_sclk; cq = bus.spi_cs_n; bq = bus.busy;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic wait_idle(output bit to);
      to = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (bus.busy === 1'b0) begin
            to = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic wait_dv(input int n0, output bit to);
      to = 1'b1;
      for (int i = 0; i < 400; i++) begin
         tick();
         if (dv_cnt > n0) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic pulse_trig();
      bus.trig = 1'b1;
      tick();
      bus.trig = 1'b0;
   endtask

   // Stimulus only: wait for IDLE, trigger one read and wait for its data_valid.
   task automatic run_read(input logic [15:0] f, output int tcyc, output int n0, output bit to);
      dev_frame = f;
      tcyc = -1;
      n0 = dv_cnt;
      wait_idle(to);
      if (!to) begin
         rises.delete();
         n0 = dv_cnt;
         tcyc = cyc;
         pulse_trig();
         wait_dv(n0, to);
      end
   endtask

   task automatic test_reset();
      int r0;
      bit to;
      bus.enable = 1'b0;
      bus.trig = 1'b0;
      #2 rst = 1'b1;
      repeat (3) tick();
      checks++; if (bus.spi_cs_n !== 1'b1) begin failures++; $display("FAIL reset_cs_n got=%b exp=1", bus.spi_cs_n); end
      checks++; if (bus.spi_sclk !== 1'b0) begin failures++; $display("FAIL reset_sclk got=%b exp=0", bus.spi_sclk); end
      checks++; if (bus.temp_raw !== 12'h000) begin failures++; $display("FAIL reset_temp_raw got=%h exp=000", bus.temp_raw); end
      checks++; if (bus.temp_int !== 10'd0) begin failures++; $display("FAIL reset_temp_int got=%0d exp=0", bus.temp_int); end
      checks++; if (bus.tc_open !== 1'b0) begin failures++; $display("FAIL reset_tc_open got=%b exp=0", bus.tc_open); end
      checks++; if (bus.frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b exp=0", bus.frame_err); end
      checks++; if (bus.data_valid !== 1'b0) begin failures++; $display("FAIL reset_data_valid got=%b exp=0", bus.data_valid); end
      checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", bus.busy); end
      // Trig during the post-reset conversion wait must be held as pending and served afterwards.
      dev_frame = 16'h1A58;
      rst = 1'b0;
      r0 = cyc;
      repeat (10) tick();
      pulse_trig();
      wait_dv(0, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL reset_pending_timeout got=%b exp=0", to); end
      checks++; if (busylow_cyc - r0 !== CONV) begin failures++; $display("FAIL reset_busy_hold got=%0d exp=%0d", busylow_cyc - r0, CONV); end
      checks++; if (csfall_cyc - r0 !== CONV + 1) begin failures++; $display("FAIL reset_first_cs_fall got=%0d exp=%0d", csfall_cyc - r0, CONV + 1); end
      checks++; if (bus.temp_raw !== m_raw(dev_frame)) begin failures++; $display("FAIL reset_pending_raw got=%h exp=%h", bus.temp_raw, m_raw(dev_frame)); end
      last_frame = dev_frame;
   endtask

   task automatic test_basic_frame();
      int tcyc, n0, bad;
      bit to;
      run_read(16'h0C80, tcyc, n0, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", to); end
      checks++; if (dv_cyc - tcyc + 1 !== LAT) begin failures++; $display("FAIL basic_latency got=%0d exp=%0d", dv_cyc - tcyc + 1, LAT); end
      checks++; if (rises.size() !== 16) begin failures++; $display("FAIL basic_rise_count got=%0d exp=16", rises.size()); end
      bad = 0;
      for (int i = 1; i < rises.size(); i++) if (rises[i] - rises[i-1] != 2 * HALF) bad++;
      checks++; if (bad !== 0) begin failures++; $display("FAIL basic_rise_spacing got=%0d_bad exp=0_bad", bad); end
      checks++; if (rises.size() == 0 || rises[0] - csfall_cyc < SETUP) begin failures++; $display("FAIL basic_cs_setup got=%0d exp>=%0d", (rises.size() == 0) ? -1 : rises[0] - csfall_cyc, SETUP); end
      checks++; if (bus.temp_raw !== 12'h190) begin failures++; $display("FAIL basic_temp_raw got=%h exp=190", bus.temp_raw); end
      checks++; if (bus.temp_int !== 10'd100) begin failures++; $display("FAIL basic_temp_int got=%0d exp=100", bus.temp_int); end
      checks++; if (bus.tc_open !== 1'b0 || bus.frame_err !== 1'b0) begin failures++; $display("FAIL basic_flags got=%b%b exp=00", bus.tc_open, bus.frame_err); end
      repeat (3) tick();
      checks++; if (dv_cnt !== n0 + 1) begin failures++; $display("FAIL basic_single_pulse got=%0d exp=%0d", dv_cnt - n0, 1); end
      last_frame = 16'h0C80;
   endtask

   task automatic test_flags();
      logic [15:0] frames [4];
      int tcyc, n0;
      bit to;
      frames[0] = 16'h0004; frames[1] = 16'h8002; frames[2] = 16'h0C80; frames[3] = 16'h0002;
      foreach (frames[k]) begin
         run_read(frames[k], tcyc, n0, to);
         checks++; if (to !== 1'b0) begin failures++; $display("FAIL flags_timeout frame=%h", frames[k]); end
         checks++; if (bus.temp_raw !== m_raw(frames[k])) begin failures++; $display("FAIL flags_temp_raw frame=%h got=%h exp=%h", frames[k], bus.temp_raw, m_raw(frames[k])); end
         checks++; if (bus.tc_open !== m_open(frames[k])) begin failures++; $display("FAIL flags_tc_open frame=%h got=%b exp=%b", frames[k], bus.tc_open, m_open(frames[k])); end
         checks++; if (bus.frame_err !== m_err(frames[k])) begin failures++; $display("FAIL flags_frame_err frame=%h got=%b exp=%b", frames[k], bus.frame_err, m_err(frames[k])); end
         last_frame = frames[k];
      end
   endtask

   task automatic test_random();
      logic [15:0] f;
      int tcyc, n0;
      bit to;
      for (int k = 0; k < 6; k++) begin
         f = 16'($urandom);
         wait_idle(to);
         checks++; if (bus.temp_raw !== m_raw(last_frame) || bus.tc_open !== m_open(last_frame) || bus.frame_err !== m_err(last_frame)) begin
            failures++; $display("FAIL rand_hold got=%h/%b/%b exp=%h/%b/%b", bus.temp_raw, bus.tc_open, bus.frame_err, m_raw(last_frame), m_open(last_frame), m_err(last_frame));
         end
         run_read(f, tcyc, n0, to);
         checks++; if (to !== 1'b0) begin failures++; $display("FAIL rand_timeout frame=%h", f); end
         checks++; if (dv_cyc - tcyc + 1 !== LAT) begin failures++; $display("FAIL rand_latency got=%0d exp=%0d", dv_cyc - tcyc + 1, LAT); end
         checks++; if (bus.temp_raw !== m_raw(f) || bus.temp_int !== m_int(f)) begin failures++; $display("FAIL rand_temp frame=%h got=%h/%0d exp=%h/%0d", f, bus.temp_raw, bus.temp_int, m_raw(f), m_int(f)); end
         checks++; if (bus.tc_open !== m_open(f) || bus.frame_err !== m_err(f)) begin failures++; $display("FAIL rand_flags frame=%h got=%b%b exp=%b%b", f, bus.tc_open, bus.frame_err, m_open(f), m_err(f)); end
         last_frame = f;
      end
   endtask

   task automatic test_back_to_back();
      int n0, d1, d2, d3, min_gap;
      bit to;
      dev_frame = 16'h0C80;
      wait_idle(to);
      n0 = dv_cnt;
      gaps.delete();
      bus.enable = 1'b1;
      wait_dv(n0, to);
      d1 = dv_cyc;
      repeat (110) tick();
      pulse_trig();
      wait_dv(n0 + 1, to);
      d2 = dv_cyc;
      repeat (120) tick();
      bus.enable = 1'b0;
      wait_dv(n0 + 2, to);
      d3 = dv_cyc;
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL b2b_timeout got=%b exp=0", to); end
      checks++; if (d2 - d1 !== PERIOD) begin failures++; $display("FAIL b2b_period1 got=%0d exp=%0d", d2 - d1, PERIOD); end
      checks++; if (d3 - d2 !== PERIOD) begin failures++; $display("FAIL b2b_period2 got=%0d exp=%0d", d3 - d2, PERIOD); end
      min_gap = 1000000;
      foreach (gaps[i]) if (gaps[i] < min_gap) min_gap = gaps[i];
      checks++; if (gaps.size() < 3 || min_gap < CONV + 1) begin failures++; $display("FAIL b2b_cs_gap got=%0d_min_of_%0d exp>=%0d", min_gap, gaps.size(), CONV + 1); end
      repeat (400) tick();
      checks++; if (dv_cnt !== n0 + 3) begin failures++; $display("FAIL b2b_extra_frame got=%0d exp=%0d", dv_cnt - n0, 3); end
      checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_busy got=%b exp=0", bus.busy); end
      last_frame = 16'h0C80;
   endtask

   task automatic test_reset_mid_frame();
      int n_before, r0, found;
      bit to;
      dev_frame = 16'h5A5A;
      wait_idle(to);
      rises.delete();
      pulse_trig();
      found = 0;
      for (int i = 0; i < 200; i++) begin
         if (rises.size() >= 7) begin found = 1; break; end
         tick();
      end
      checks++; if (found !== 1) begin failures++; $display("FAIL midrst_rise_timeout got=%0d exp=7", rises.size()); end
      n_before = dv_cnt;
      rst = 1'b1;
      #1;
      checks++; if (bus.spi_cs_n !== 1'b1 || bus.spi_sclk !== 1'b0) begin failures++; $display("FAIL midrst_pins got=%b%b exp=10", bus.spi_cs_n, bus.spi_sclk); end
      checks++; if (bus.temp_raw !== 12'h000 || bus.temp_int !== 10'd0) begin failures++; $display("FAIL midrst_temp got=%h/%0d exp=000/0", bus.temp_raw, bus.temp_int); end
      checks++; if (bus.tc_open !== 1'b0 || bus.frame_err !== 1'b0 || bus.data_valid !== 1'b0) begin failures++; $display("FAIL midrst_flags got=%b%b%b exp=000", bus.tc_open, bus.frame_err, bus.data_valid); end
      repeat (2) tick();
      rst = 1'b0;
      r0 = cyc;
      checks++; if (dv_cnt !== n_before) begin failures++; $display("FAIL midrst_partial_dv got=%0d exp=%0d", dv_cnt, n_before); end
      repeat (5) tick();
      pulse_trig();
      wait_dv(n_before, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL midrst_timeout got=%b exp=0", to); end
      checks++; if (csfall_cyc - r0 !== CONV + 1) begin failures++; $display("FAIL midrst_conv_wait got=%0d exp=%0d", csfall_cyc - r0, CONV + 1); end
      checks++; if (bus.temp_raw !== m_raw(dev_frame) || bus.frame_err !== m_err(dev_frame)) begin failures++; $display("FAIL midrst_result got=%h/%b exp=%h/%b", bus.temp_raw, bus.frame_err, m_raw(dev_frame), m_err(dev_frame)); end
      last_frame = dev_frame;
   endtask

   initial begin
      bus.enable = 1'b0;
      bus.trig = 1'b0;
      test_reset();
      test_basic_frame();
      test_flags();
      test_random();
      test_back_to_back();
      test_reset_mid_frame();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
